// File: rtl/pc_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module : pc_seq_pkg
// Purpose: Shared types and helpers for the PC sequencer: FSM state encoding,
//          redirect index width and the target alignment check.
// Ports  : none (package)
// Rev    : 1.0  initial release
// ============================================================================
package pc_seq_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int NUM_SRC_DEF = 4;

  // Index width for n sources; at least one bit so a single source still
  // has a usable index field.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int IDX_W = idx_width(NUM_SRC_DEF);

  // Target is misaligned when any bit below the instruction size is set.
  // Targets up to 64 bits wide are zero-extended by the caller.
  function automatic logic is_misaligned(input logic [63:0] target,
                                         input int          instr_bytes);
    logic [63:0] mask;
    mask = 64'(instr_bytes - 1);
    return (target & mask) != 64'd0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pc_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module : pc_sequencer_if
// Purpose: Bundle between control/branch logic (master) and the PC sequencer
//          (slave).
// Ports  : stall_i, redirect_valid_i, redirect_target_i  master -> slave
//          pc_o, pc_valid_o, flush_o, misalign_o,
//          misalign_addr_o                               slave -> master
// Rev    : 1.0  initial release
// ============================================================================
interface pc_sequencer_if #(
  parameter int XLEN    = 32,
  parameter int NUM_SRC = 4
);
  logic                    stall_i;
  logic [NUM_SRC-1:0]      redirect_valid_i;
  logic [NUM_SRC*XLEN-1:0] redirect_target_i;
  logic [XLEN-1:0]         pc_o;
  logic                    pc_valid_o;
  logic                    flush_o;
  logic                    misalign_o;
  logic [XLEN-1:0]         misalign_addr_o;

  modport master (
    output stall_i, redirect_valid_i, redirect_target_i,
    input  pc_o, pc_valid_o, flush_o, misalign_o, misalign_addr_o
  );

  modport slave (
    input  stall_i, redirect_valid_i, redirect_target_i,
    output pc_o, pc_valid_o, flush_o, misalign_o, misalign_addr_o
  );
endinterface
`default_nettype wire

// File: rtl/pc_sequencer_arbiter.sv
`default_nettype none
// ============================================================================
// Module : pc_redirect_arbiter
// Purpose: Combinational fixed-priority pick among redirect sources; the
//          lowest asserted index wins.
// Ports  : redirect_valid_i  per-source request
//          redirect_target_i flat targets, source k at [k*XLEN +: XLEN]
//          any_valid_o       at least one request
//          win_idx_o         winning index
//          win_target_o      winning target
// Rev    : 1.0  initial release
// ============================================================================
module pc_redirect_arbiter #(
  parameter int XLEN    = 32,
  parameter int NUM_SRC = 4,
  parameter int IDX_W   = 2
) (
  input  wire logic [NUM_SRC-1:0]      redirect_valid_i,
  input  wire logic [NUM_SRC*XLEN-1:0] redirect_target_i,
  output logic                         any_valid_o,
  output logic [IDX_W-1:0]             win_idx_o,
  output logic [XLEN-1:0]              win_target_o
);

  // Scan from the lowest priority upward so the last hit is the winner.
  always_comb begin
    any_valid_o  = 1'b0;
    win_idx_o    = '0;
    win_target_o = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (redirect_valid_i[k]) begin
        any_valid_o  = 1'b1;
        win_idx_o    = IDX_W'(k);
        win_target_o = redirect_target_i[k*XLEN +: XLEN];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module : pc_sequencer
// Purpose: Next-PC generator. Owns the PC register, applies prioritised
//          redirects, holds on stall while buffering one redirect, traps
//          misaligned targets and pulses flush on every redirect.
// Ports  : clk    rising-edge clock
//          rst_n  synchronous active-low reset
//          bus    pc_sequencer_if.slave (stall/redirects in, PC/status out)
// Rev    : 1.0  initial release
// ============================================================================
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter int              NUM_SRC     = 4,
  parameter int              INSTR_BYTES = 4,
  parameter logic [XLEN-1:0] RESET_VEC   = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VEC    = 32'h0000_0100
) (
  input wire logic         clk,
  input wire logic         rst_n,
  pc_sequencer_if.slave    bus
);

  localparam int SRC_IDX_W = idx_width(NUM_SRC);

  state_t                 state_q, state_d;
  logic [XLEN-1:0]        pc_q, pc_d;
  logic                   pc_valid_q, pc_valid_d;
  logic                   flush_q, flush_d;
  logic                   misalign_q, misalign_d;
  logic [XLEN-1:0]        maddr_q, maddr_d;
  logic [SRC_IDX_W-1:0]   pend_idx_q, pend_idx_d;
  logic [XLEN-1:0]        pend_tgt_q, pend_tgt_d;

  logic                   any_valid;
  logic [SRC_IDX_W-1:0]   win_idx;
  logic [XLEN-1:0]        win_target;
  logic                   apply_en;
  logic [XLEN-1:0]        apply_tgt;

  pc_redirect_arbiter #(
    .XLEN    (XLEN),
    .NUM_SRC (NUM_SRC),
    .IDX_W   (SRC_IDX_W)
  ) u_arb (
    .redirect_valid_i  (bus.redirect_valid_i),
    .redirect_target_i (bus.redirect_target_i),
    .any_valid_o       (any_valid),
    .win_idx_o         (win_idx),
    .win_target_o      (win_target)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pc_valid_d = pc_valid_q;
    flush_d    = 1'b0;
    misalign_d = 1'b0;
    maddr_d    = maddr_q;
    pend_idx_d = pend_idx_q;
    pend_tgt_d = pend_tgt_q;
    apply_en   = 1'b0;
    apply_tgt  = '0;

    case (state_q)
      BOOT: begin
        pc_valid_d = 1'b1;
        state_d    = RUN;
      end
      RUN: begin
        if (!bus.stall_i) begin
          if (any_valid) begin
            apply_en  = 1'b1;
            apply_tgt = win_target;
          end else begin
            pc_d = pc_q + XLEN'(INSTR_BYTES);
          end
        end else if (any_valid) begin
          pend_idx_d = win_idx;
          pend_tgt_d = win_target;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (bus.stall_i) begin
          // Equal index replaces: the newer request from the same source
          // supersedes the buffered one.
          if (any_valid && (win_idx <= pend_idx_q)) begin
            pend_idx_d = win_idx;
            pend_tgt_d = win_target;
          end
        end else begin
          // On release the buffered entry wins an equal index.
          apply_en   = 1'b1;
          apply_tgt  = (any_valid && (win_idx < pend_idx_q)) ? win_target : pend_tgt_q;
          pend_idx_d = '0;
          pend_tgt_d = '0;
          state_d    = RUN;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase

    if (apply_en) begin
      flush_d = 1'b1;
      if (is_misaligned(64'(apply_tgt), INSTR_BYTES)) begin
        pc_d       = TRAP_VEC;
        misalign_d = 1'b1;
        maddr_d    = apply_tgt;
      end else begin
        pc_d = apply_tgt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VEC;
      pc_valid_q <= 1'b0;
      flush_q    <= 1'b0;
      misalign_q <= 1'b0;
      maddr_q    <= '0;
      pend_idx_q <= '0;
      pend_tgt_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_valid_q <= pc_valid_d;
      flush_q    <= flush_d;
      misalign_q <= misalign_d;
      maddr_q    <= maddr_d;
      pend_idx_q <= pend_idx_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

  assign bus.pc_o            = pc_q;
  assign bus.pc_valid_o      = pc_valid_q;
  assign bus.flush_o         = flush_q;
  assign bus.misalign_o      = misalign_q;
  assign bus.misalign_addr_o = maddr_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_pc_sequencer
// Purpose: Self-checking bench for pc_sequencer: directed scenarios followed
//          by randomized traffic, all checked against a behavioural model.
// Ports  : none
// Rev    : 1.0  initial release
// ============================================================================
module tb_pc_sequencer;

  localparam int          XLEN    = 32;
  localparam int          NSRC    = 4;
  localparam logic [31:0] TRAPV   = 32'h0000_0100;
  localparam logic [31:0] RSTV    = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pc_sequencer_if #(.XLEN(XLEN), .NUM_SRC(NSRC)) bus ();

  pc_sequencer #(
    .XLEN(XLEN), .NUM_SRC(NSRC), .INSTR_BYTES(4),
    .RESET_VEC(RSTV), .TRAP_VEC(TRAPV)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: "booted" flag plus an optional pending request.
  logic [31:0] m_pc, m_maddr;
  logic        m_valid, m_flush, m_mis, m_booted;
  logic        m_pend;
  int          m_pidx;
  logic [31:0] m_ptgt;
  logic [31:0] tg [NSRC];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_apply(input logic [31:0] t);
    m_flush = 1'b1;
    if (t[1:0] != 2'b00) begin
      m_pc    = TRAPV;
      m_mis   = 1'b1;
      m_maddr = t;
    end else begin
      m_pc = t;
    end
  endtask

  task automatic model_step(input logic r, input logic st, input logic [NSRC-1:0] v);
    int w;
    w = -1;
    for (int k = 0; k < NSRC; k++) if (v[k] && w < 0) w = k;
    if (!r) begin
      m_pc = RSTV; m_valid = 0; m_flush = 0; m_mis = 0; m_maddr = 0;
      m_booted = 0; m_pend = 0;
    end else begin
      m_flush = 0; m_mis = 0;
      if (!m_booted) begin
        m_booted = 1; m_valid = 1;
      end else if (!st) begin
        if (m_pend && (w < 0 || m_pidx <= w)) model_apply(m_ptgt);
        else if (w >= 0)                      model_apply(tg[w]);
        else                                  m_pc = m_pc + 32'd4;
        m_pend = 0;
      end else if (w >= 0 && (!m_pend || w <= m_pidx)) begin
        m_pend = 1; m_pidx = w; m_ptgt = tg[w];
      end
    end
  endtask

  // Drive one cycle, advance the model, sample after the edge, compare.
  task automatic tick(input logic r, input logic st, input logic [NSRC-1:0] v);
    rst_n = r;
    bus.stall_i = st;
    bus.redirect_valid_i = v;
    for (int k = 0; k < NSRC; k++) bus.redirect_target_i[k*XLEN +: XLEN] = tg[k];
    model_step(r, st, v);
    @(posedge clk);
    #1;
    chk("pc",       bus.pc_o,                    m_pc);
    chk("pc_valid", {31'd0, bus.pc_valid_o},     {31'd0, m_valid});
    chk("flush",    {31'd0, bus.flush_o},        {31'd0, m_flush});
    chk("misalign", {31'd0, bus.misalign_o},     {31'd0, m_mis});
    chk("maddr",    bus.misalign_addr_o,         m_maddr);
  endtask

  initial begin
    for (int k = 0; k < NSRC; k++) tg[k] = 32'h0;
    m_pend = 0; m_pidx = 0; m_ptgt = 0; m_booted = 0;
    m_pc = 0; m_valid = 0; m_flush = 0; m_mis = 0; m_maddr = 0;
    rst_n = 0; bus.stall_i = 0; bus.redirect_valid_i = '0; bus.redirect_target_i = '0;
    @(negedge clk);

    // 1: reset and boot sequence
    tick(0, 0, 4'b0000);
    chk("t1_rst_pc", bus.pc_o, 32'h0);
    chk("t1_rst_valid", {31'd0, bus.pc_valid_o}, 32'd0);
    tick(1, 0, 4'b0000);
    chk("t1_boot_pc", bus.pc_o, 32'h0);
    chk("t1_boot_valid", {31'd0, bus.pc_valid_o}, 32'd1);
    tick(1, 0, 4'b0000); chk("t1_pc4", bus.pc_o, 32'h4);
    tick(1, 0, 4'b0000); chk("t1_pc8", bus.pc_o, 32'h8);
    tick(1, 0, 4'b0000); chk("t1_pcC", bus.pc_o, 32'hC);
    tick(1, 0, 4'b0000); chk("t1_pc10", bus.pc_o, 32'h10);

    // 2: two simultaneous redirects, lower index wins
    tg[2] = 32'h200; tg[3] = 32'h300;
    tick(1, 0, 4'b1100);
    chk("t2_pc", bus.pc_o, 32'h200);
    chk("t2_flush", {31'd0, bus.flush_o}, 32'd1);
    tick(1, 0, 4'b0000);
    chk("t2_seq", bus.pc_o, 32'h204);
    chk("t2_flush_clr", {31'd0, bus.flush_o}, 32'd0);

    // 3: stall with a higher priority request replacing the buffered one
    tg[0] = 32'h40; tick(1, 0, 4'b0001);
    tg[3] = 32'h80; tick(1, 1, 4'b1000);
    tg[1] = 32'h90; tick(1, 1, 4'b0010);
    tick(1, 1, 4'b0000);
    chk("t3_hold", bus.pc_o, 32'h40);
    tick(1, 0, 4'b0000);
    chk("t3_pc", bus.pc_o, 32'h90);
    chk("t3_flush", {31'd0, bus.flush_o}, 32'd1);

    // 4: pending beats a lower priority request at release
    tick(1, 1, 4'b0010);
    tg[2] = 32'hA0; tick(1, 0, 4'b0100);
    chk("t4_pc", bus.pc_o, 32'h90);
    tick(1, 0, 4'b0000);
    chk("t4_seq", bus.pc_o, 32'h94);
    // equal index at release: buffered target wins
    tick(1, 1, 4'b0010);
    tg[1] = 32'hC0; tick(1, 0, 4'b0010);
    chk("t4_eq", bus.pc_o, 32'h90);

    // 5: misaligned redirect traps
    tg[0] = 32'h102; tick(1, 0, 4'b0001);
    chk("t5_pc", bus.pc_o, TRAPV);
    chk("t5_mis", {31'd0, bus.misalign_o}, 32'd1);
    chk("t5_addr", bus.misalign_addr_o, 32'h102);
    tick(1, 0, 4'b0000);
    chk("t5_mis_clr", {31'd0, bus.misalign_o}, 32'd0);
    chk("t5_addr_held", bus.misalign_addr_o, 32'h102);

    // 6: wraparound, then reset during HOLD
    tg[0] = 32'hFFFF_FFFC; tick(1, 0, 4'b0001);
    tick(1, 0, 4'b0000);
    chk("t6_wrap", bus.pc_o, 32'h0);
    tg[1] = 32'h500; tick(1, 1, 4'b0010);
    tick(0, 1, 4'b0000);
    chk("t6_rst_pc", bus.pc_o, RSTV);
    chk("t6_rst_addr", bus.misalign_addr_o, 32'h0);
    // stall and redirects are ignored during BOOT
    tg[0] = 32'h700; tick(1, 1, 4'b0001);
    chk("t6_boot", bus.pc_o, RSTV);
    tick(1, 0, 4'b0000);
    chk("t6_nopend", bus.pc_o, 32'h4);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [NSRC-1:0] v;
      logic st, r;
      r  = ($urandom_range(0, 79) != 0);
      st = ($urandom_range(0, 2) == 0);
      for (int k = 0; k < NSRC; k++) begin
        v[k] = ($urandom_range(0, 5) == 0);
        case ($urandom_range(0, 9))
          0:       tg[k] = $urandom();
          1:       tg[k] = 32'hFFFF_FFFC;
          default: tg[k] = {$urandom_range(0, 32'h3FFF), 2'b00};
        endcase
      end
      tick(r, st, v);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
